fpaddsub_execute_pipe: RTL and testbench

//  Pipelined, parametrised mantissa add/sub stage of the FP adder datapath. Sits between align and normalise.

---
 rtl/fpaddsub_execute_pipe_if.sv | 37 +++
 rtl/fpaddsub_execute_pipe.sv | 165 ++++++++++++++++
 tb/tb_fpaddsub_execute_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpaddsub_execute_pipe_if.sv
// Handshake and data bus of the FP add/sub mantissa execute stage.
// The master side drives operations in and accepts results; the slave side is the stage itself.
interface fpaddsub_execute_pipe_if #(
  parameter int MAN_W = 23,
  parameter int TAG_W = 8
);
  localparam int MW = MAN_W + 2;

  logic              in_valid;
  logic              in_ready;
  logic [MW-1:0]     mmax;
  logic [2*MW-1:0]   mmin;
  logic              smax;
  logic              smin;
  logic              op_mode;
  logic [TAG_W-1:0]  tag_in;

  logic              out_valid;
  logic              out_ready;
  logic [MW:0]       sum;
  logic              opr;
  logic              cout;
  logic              guard;
  logic              sticky;
  logic              zero;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output in_valid, mmax, mmin, smax, smin, op_mode, tag_in, out_ready,
    input  in_ready, out_valid, sum, opr, cout, guard, sticky, zero, tag_out
  );

  modport slave (
    input  in_valid, mmax, mmin, smax, smin, op_mode, tag_in, out_ready,
    output in_ready, out_valid, sum, opr, cout, guard, sticky, zero, tag_out
  );
endinterface

// File: rtl/fpaddsub_execute_pipe.sv
// Mantissa add/sub stage of the FP adder, between align and normalise.
// Resolves the effective op, extracts guard/sticky from the shifted-out bits,
// forms the 1's-complement subtrahend with a compensating carry and produces the
// raw (MW+1)-bit sum. PIPE=2 splits operand prep and the adder across two
// registers; any value other than 2 builds the single-register form (only 1 and
// 2 are legal). Valid/ready flow control lets normalise/round stall the stage.
module fpaddsub_execute_pipe #(
  parameter int MAN_W = 23,
  parameter int PIPE  = 2,
  parameter int TAG_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  fpaddsub_execute_pipe_if.slave  bus
);
  localparam int MW = MAN_W + 2;

  logic             guard_c;
  logic             sticky_c;
  logic             opr_c;
  logic             opc_c;
  logic [MW:0]      b_c;
  logic [MW:0]      opb_c;

  logic             in_ready_c;
  logic             accept;
  logic             out_fire;

  logic             o_valid;
  logic [MW:0]      o_sum;
  logic             o_opr;
  logic             o_cout;
  logic             o_guard;
  logic             o_sticky;
  logic             o_zero;
  logic [TAG_W-1:0] o_tag;

  // Operand preparation: effective op, rounding bits and the possibly inverted subtrahend.
  // The +1 that turns ~b into -b is only added when nothing was shifted out; otherwise the
  // missing +1 acts as the borrow from the discarded fraction.
  always_comb begin
    guard_c  = bus.mmin[MW-1];
    sticky_c = |bus.mmin[MW-2:0];
    opr_c    = bus.op_mode ^ bus.smax ^ bus.smin;
    b_c      = {1'b0, bus.mmin[2*MW-1:MW]};
    opb_c    = opr_c ? ~b_c : b_c;
    opc_c    = opr_c & ~(guard_c | sticky_c);
  end

  assign accept   = bus.in_valid & in_ready_c;
  assign out_fire = o_valid & bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = o_valid;
  assign bus.sum       = o_sum;
  assign bus.opr       = o_opr;
  assign bus.cout      = o_cout;
  assign bus.guard     = o_guard;
  assign bus.sticky    = o_sticky;
  assign bus.zero      = o_zero;
  assign bus.tag_out   = o_tag;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic             s1_valid;
      logic [MW-1:0]    s1_mmax;
      logic [MW:0]      s1_opb;
      logic             s1_opc;
      logic             s1_opr;
      logic             s1_guard;
      logic             s1_sticky;
      logic [TAG_W-1:0] s1_tag;
      logic             s1_moves;
      logic [MW:0]      sum_c;
      logic             zero_c;

      assign s1_moves   = s1_valid & (~o_valid | out_fire);
      assign in_ready_c = ~s1_valid | s1_moves;
      assign sum_c      = {1'b0, s1_mmax} + s1_opb + {{MW{1'b0}}, s1_opc};
      assign zero_c     = (sum_c == '0) & ~s1_guard & ~s1_sticky;

      // Operand register: loads on accept, empties when its op moves to the sum register.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_valid  <= 1'b0;
          s1_mmax   <= '0;
          s1_opb    <= '0;
          s1_opc    <= 1'b0;
          s1_opr    <= 1'b0;
          s1_guard  <= 1'b0;
          s1_sticky <= 1'b0;
          s1_tag    <= '0;
        end else if (accept) begin
          s1_valid  <= 1'b1;
          s1_mmax   <= bus.mmax;
          s1_opb    <= opb_c;
          s1_opc    <= opc_c;
          s1_opr    <= opr_c;
          s1_guard  <= guard_c;
          s1_sticky <= sticky_c;
          s1_tag    <= bus.tag_in;
        end else if (s1_moves) begin
          s1_valid  <= 1'b0;
        end
      end

      // Sum register: captures the adder result when the operand stage moves on, holds under stall.
      always_ff @(posedge clk) begin
        if (rst) begin
          o_valid  <= 1'b0;
          o_sum    <= '0;
          o_opr    <= 1'b0;
          o_cout   <= 1'b0;
          o_guard  <= 1'b0;
          o_sticky <= 1'b0;
          o_zero   <= 1'b0;
          o_tag    <= '0;
        end else if (s1_moves) begin
          o_valid  <= 1'b1;
          o_sum    <= sum_c;
          o_opr    <= s1_opr;
          o_cout   <= s1_opc;
          o_guard  <= s1_guard;
          o_sticky <= s1_sticky;
          o_zero   <= zero_c;
          o_tag    <= s1_tag;
        end else if (out_fire) begin
          o_valid  <= 1'b0;
        end
      end
    end else begin : g_pipe1
      logic [MW:0] sum_c;
      logic        zero_c;

      assign in_ready_c = ~o_valid | out_fire;
      assign sum_c      = {1'b0, bus.mmax} + opb_c + {{MW{1'b0}}, opc_c};
      assign zero_c     = (sum_c == '0) & ~guard_c & ~sticky_c;

      // Single result register after the full operand prep and add.
      always_ff @(posedge clk) begin
        if (rst) begin
          o_valid  <= 1'b0;
          o_sum    <= '0;
          o_opr    <= 1'b0;
          o_cout   <= 1'b0;
          o_guard  <= 1'b0;
          o_sticky <= 1'b0;
          o_zero   <= 1'b0;
          o_tag    <= '0;
        end else if (accept) begin
          o_valid  <= 1'b1;
          o_sum    <= sum_c;
          o_opr    <= opr_c;
          o_cout   <= opc_c;
          o_guard  <= guard_c;
          o_sticky <= sticky_c;
          o_zero   <= zero_c;
          o_tag    <= bus.tag_in;
        end else if (out_fire) begin
          o_valid  <= 1'b0;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_fpaddsub_execute_pipe.sv
// Bench for fpaddsub_execute_pipe: a PIPE=2 and a PIPE=1 instance driven with the same
// stimulus, each checked against an arithmetic reference model and an in-order scoreboard,
// plus hand-computed literal cases, back-pressure and mid-stream reset scenarios.
module tb_fpaddsub_execute_pipe;
  localparam int MAN_W = 23;
  localparam int TAG_W = 8;
  localparam int MW    = MAN_W + 2;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [MW:0]      sum;
    logic             opr;
    logic             cout;
    logic             guard;
    logic             sticky;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  exp_t board [2][DEPTH];
  int   head  [2];
  int   cnt   [2];
  logic hold  [2];
  exp_t last  [2];
  int   seen2 [$];

  fpaddsub_execute_pipe_if #(.MAN_W(MAN_W), .TAG_W(TAG_W)) if2 ();
  fpaddsub_execute_pipe_if #(.MAN_W(MAN_W), .TAG_W(TAG_W)) if1 ();

  fpaddsub_execute_pipe #(.MAN_W(MAN_W), .PIPE(2), .TAG_W(TAG_W)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  fpaddsub_execute_pipe #(.MAN_W(MAN_W), .PIPE(1), .TAG_W(TAG_W)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference: plain modular add, or subtract with a borrow when bits were shifted out.
  function automatic exp_t model(input logic [MW-1:0] a, input logic [2*MW-1:0] m,
                                 input logic sa, input logic sb, input logic op,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    longint unsigned av, bv, r;
    logic g, s, sub;
    g   = m[MW-1];
    s   = (m[MW-2:0] != '0);
    sub = (sa != sb) ? !op : op;
    av  = 64'(a);
    bv  = 64'(m[2*MW-1:MW]);
    if (!sub) r = av + bv;
    else      r = av - bv - ((g || s) ? 64'd1 : 64'd0);
    r = r & ((64'd1 << (MW + 1)) - 64'd1);
    e.sum    = r[MW:0];
    e.opr    = sub;
    e.cout   = sub && !(g || s);
    e.guard  = g;
    e.sticky = s;
    e.zero   = (r == 64'd0) && !g && !s;
    e.tag    = tag;
    return e;
  endfunction

  function automatic exp_t mkExp(input logic [MW:0] sum, input logic opr, input logic cout,
                                 input logic guard, input logic sticky, input logic zero,
                                 input logic [TAG_W-1:0] tag);
    exp_t e;
    e.sum = sum; e.opr = opr; e.cout = cout; e.guard = guard;
    e.sticky = sticky; e.zero = zero; e.tag = tag;
    return e;
  endfunction

  function automatic exp_t getOut(input int id);
    exp_t e;
    if (id == 0) begin
      e.sum = if2.sum; e.opr = if2.opr; e.cout = if2.cout; e.guard = if2.guard;
      e.sticky = if2.sticky; e.zero = if2.zero; e.tag = if2.tag_out;
    end else begin
      e.sum = if1.sum; e.opr = if1.opr; e.cout = if1.cout; e.guard = if1.guard;
      e.sticky = if1.sticky; e.zero = if1.zero; e.tag = if1.tag_out;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t got, input exp_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got sum=%h opr=%b cout=%b guard=%b sticky=%b zero=%b tag=%h; want sum=%h opr=%b cout=%b guard=%b sticky=%b zero=%b tag=%h",
               name, got.sum, got.opr, got.cout, got.guard, got.sticky, got.zero, got.tag,
               want.sum, want.opr, want.cout, want.guard, want.sticky, want.zero, want.tag);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  task automatic applyStimulus(input logic v, input logic [MW-1:0] a, input logic [2*MW-1:0] m,
                               input logic sa, input logic sb, input logic op,
                               input logic [TAG_W-1:0] tag);
    if2.in_valid = v; if2.mmax = a; if2.mmin = m; if2.smax = sa; if2.smin = sb;
    if2.op_mode = op; if2.tag_in = tag;
    if1.in_valid = v; if1.mmax = a; if1.mmin = m; if1.smax = sa; if1.smin = sb;
    if1.op_mode = op; if1.tag_in = tag;
  endtask

  task automatic setReady(input logic r);
    if2.out_ready = r;
    if1.out_ready = r;
  endtask

  task automatic randOp(output logic [MW-1:0] a, output logic [2*MW-1:0] m,
                        output logic sa, output logic sb, output logic op);
    logic [63:0] r64;
    logic [31:0] r32;
    r64 = {$urandom, $urandom};
    r32 = $urandom;
    m   = r64[2*MW-1:0];
    if ($urandom_range(0, 2) == 0) m[MW-1:0] = '0;
    a   = r32[MW-1:0];
    if ($urandom_range(0, 7) == 0) a = m[2*MW-1:MW];
    sa  = 1'($urandom_range(0, 1));
    sb  = 1'($urandom_range(0, 1));
    op  = 1'($urandom_range(0, 1));
  endtask

  // Per-instance scoreboard: occupancy-based ready check, stall stability, in-order results.
  task automatic monitorDut(input int id, input int pipe);
    logic iv, ir, ov, orr, sa, sb, op;
    logic [MW-1:0] a;
    logic [2*MW-1:0] m;
    logic [TAG_W-1:0] tg;
    exp_t got;
    string sfx;
    sfx = (id == 0) ? "_p2" : "_p1";
    if (id == 0) begin
      iv = if2.in_valid; ir = if2.in_ready; ov = if2.out_valid; orr = if2.out_ready;
      a = if2.mmax; m = if2.mmin; sa = if2.smax; sb = if2.smin; op = if2.op_mode; tg = if2.tag_in;
    end else begin
      iv = if1.in_valid; ir = if1.in_ready; ov = if1.out_valid; orr = if1.out_ready;
      a = if1.mmax; m = if1.mmin; sa = if1.smax; sb = if1.smin; op = if1.op_mode; tg = if1.tag_in;
    end
    got = getOut(id);
    if (rst) begin
      cnt[id] = 0; head[id] = 0; hold[id] = 1'b0;
      return;
    end
    if (hold[id]) begin
      checkBit({"stall_valid", sfx}, ov, 1'b1);
      checkOutput({"stall_hold", sfx}, got, last[id]);
    end
    checkBit({"in_ready", sfx}, ir, (cnt[id] < pipe) || (ov && orr));
    if (cnt[id] == 0) checkBit({"idle_valid", sfx}, ov, 1'b0);
    if (ov && orr && cnt[id] > 0) begin
      checkOutput({"result", sfx}, got, board[id][head[id]]);
      head[id] = (head[id] + 1) % DEPTH;
      cnt[id]--;
      if (id == 0) seen2.push_back(int'(got.tag));
    end
    if (iv && ir) begin
      board[id][(head[id] + cnt[id]) % DEPTH] = model(a, m, sa, sb, op, tg);
      cnt[id]++;
    end
    hold[id] = ov && !orr;
    last[id] = got;
  endtask

  // Compare process: both instances are checked on every falling edge.
  always @(negedge clk) begin
    monitorDut(0, 2);
    monitorDut(1, 1);
  end

  // One op into an empty pipe with out_ready high; PIPE=1 answers after 1 cycle, PIPE=2 after 2.
  task automatic directedOp(input string name, input logic [MW-1:0] a, input logic [2*MW-1:0] m,
                            input logic sa, input logic sb, input logic op,
                            input logic [TAG_W-1:0] tag, input exp_t lit);
    checkOutput({name, "_model"}, model(a, m, sa, sb, op, tag), lit);
    setReady(1'b1);
    applyStimulus(1'b1, a, m, sa, sb, op, tag);
    @(negedge clk);
    checkBit({name, "_p2_idle"}, if2.out_valid, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, a, m, sa, sb, op, tag);
    @(negedge clk);
    checkBit({name, "_p1_valid"}, if1.out_valid, 1'b1);
    checkOutput({name, "_p1"}, getOut(1), lit);
    checkBit({name, "_p2_early"}, if2.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkBit({name, "_p2_valid"}, if2.out_valid, 1'b1);
    checkOutput({name, "_p2"}, getOut(0), lit);
    @(posedge clk); #1;
  endtask

  // Five tagged ops while the output is stalled for four cycles.
  task automatic backPressure();
    int acc;
    acc = 0;
    seen2.delete();
    fork
      begin
        logic [MW-1:0] a;
        logic [2*MW-1:0] m;
        logic sa, sb, op;
        int waited;
        for (int t = 1; t <= 5; t++) begin
          randOp(a, m, sa, sb, op);
          applyStimulus(1'b1, a, m, sa, sb, op, TAG_W'(t));
          waited = 0;
          @(negedge clk);
          while (!if2.in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
          end
          if (waited >= 40) failNow("bp_accept");
          @(posedge clk);
          acc++;
          #1;
        end
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
      end
      begin
        setReady(1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkInt("bp_accepts", acc, 2);
        checkBit("bp_in_ready", if2.in_ready, 1'b0);
        checkBit("bp_out_valid", if2.out_valid, 1'b1);
        checkInt("bp_tag_held", int'(if2.tag_out), 1);
        @(posedge clk); #1;
        setReady(1'b1);
      end
    join
    repeat (6) @(posedge clk);
    #1;
    checkInt("bp_count", seen2.size(), 5);
    for (int i = 0; i < seen2.size() && i < 5; i++)
      checkInt($sformatf("bp_order_%0d", i), seen2[i], i + 1);
  endtask

  // Main sequence.
  initial begin
    logic [MW-1:0] a;
    logic [2*MW-1:0] m;
    logic sa, sb, op;

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    setReady(1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkBit("reset_valid_p2", if2.out_valid, 1'b0);
    checkBit("reset_valid_p1", if1.out_valid, 1'b0);
    checkBit("reset_ready_p2", if2.in_ready, 1'b1);
    checkOutput("reset_out_p2", getOut(0), '0);
    checkOutput("reset_out_p1", getOut(1), '0);
    @(posedge clk); #1;

    directedOp("add_1p1", 25'h0800000, {25'h0800000, 25'h0}, 1'b0, 1'b0, 1'b0, 8'h11,
               mkExp(26'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
    directedOp("cancel", 25'h0800000, {25'h0800000, 25'h0}, 1'b0, 1'b0, 1'b1, 8'h12,
               mkExp(26'h0000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12));
    directedOp("sub_sticky", 25'h0800000, {25'h0800000, 25'h0000001}, 1'b0, 1'b0, 1'b1, 8'h13,
               mkExp(26'h3FFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h13));
    directedOp("sign_sub", 25'h0800000, {25'h0400000, 25'h1000000}, 1'b0, 1'b1, 1'b0, 8'h14,
               mkExp(26'h03FFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h14));
    directedOp("add_carry", 25'h1FFFFFF, {25'h1FFFFFF, 25'h0FFFFFF}, 1'b1, 1'b1, 1'b0, 8'h15,
               mkExp(26'h3FFFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h15));
    directedOp("sign_add", 25'h1000000, {25'h0000001, 25'h0}, 1'b1, 1'b0, 1'b1, 8'h16,
               mkExp(26'h1000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h16));

    backPressure();

    setReady(1'b0);
    applyStimulus(1'b1, 25'h0123456, {25'h0012345, 25'h0}, 1'b0, 1'b0, 1'b0, 8'hA1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 25'h0654321, {25'h0054321, 25'h0}, 1'b0, 1'b0, 1'b1, 8'hA2);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkBit("rst_mid_valid_p2", if2.out_valid, 1'b0);
    checkBit("rst_mid_valid_p1", if1.out_valid, 1'b0);
    checkBit("rst_mid_ready_p2", if2.in_ready, 1'b1);
    checkBit("rst_mid_ready_p1", if1.in_ready, 1'b1);
    checkOutput("rst_mid_out_p2", getOut(0), '0);
    @(posedge clk); #1;
    directedOp("after_rst", 25'h0800000, {25'h0800000, 25'h0}, 1'b0, 1'b0, 1'b0, 8'h21,
               mkExp(26'h1000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21));

    for (int i = 0; i < 400; i++) begin
      randOp(a, m, sa, sb, op);
      applyStimulus(1'($urandom_range(0, 3) != 0), a, m, sa, sb, op, 8'($urandom));
      setReady(1'($urandom_range(0, 3) != 0));
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
    setReady(1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkInt("drain_p2", cnt[0], 0);
    checkInt("drain_p1", cnt[1], 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
